harv_dmem_wb_bridge: RTL

Converts the HARV core's data-memory request interface (req/wren/size/unsigned/addr/wdata, gnt/err/rdata) into a single-outstanding Wishbone classic master cycle toward the Controller's second memory port.

---
 rtl/harv_dmem_wb_bridge.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/harv_dmem_wb_bridge.sv
// Bridges the HARV data-memory request port onto a single-outstanding Wishbone
// classic master, handling lane selects, store replication, load extension and timeout.
module harv_dmem_wb_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dmem_req_i,
   input  logic                  dmem_wren_i,
   input  logic [1:0]            dmem_size_i,
   input  logic                  dmem_usgn_i,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [31:0]           dmem_wdata_i,
   output logic                  dmem_gnt_o,
   output logic                  dmem_err_o,
   output logic [31:0]           dmem_rdata_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [3:0]            wb_sel_o,
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   output logic [31:0]           wb_data_o,
   input  logic [31:0]           wb_data_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);

   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   state_e                state_q, state_d;
   logic                  cyc_q, cyc_d;
   logic                  we_q, we_d;
   logic [3:0]            sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdat_q, wdat_d;
   logic                  gnt_q, gnt_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            size_q, size_d;
   logic                  usgn_q, usgn_d;
   logic [1:0]            lane_q, lane_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  misaligned;
   logic                  timeout_hit;
   logic [3:0]            lane_sel;
   logic [31:0]           lane_data;
   logic [31:0]           load_ext;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;

   // Request decode: alignment, byte-lane selects and replicated store data.
   always_comb begin
      misaligned = 1'b0;
      lane_sel   = 4'b1111;
      lane_data  = dmem_wdata_i;
      case (dmem_size_i)
         2'b00: begin
            lane_sel  = 4'b0001 << dmem_addr_i[1:0];
            lane_data = {4{dmem_wdata_i[7:0]}};
         end
         2'b01: begin
            misaligned = dmem_addr_i[0];
            lane_sel   = dmem_addr_i[1] ? 4'b1100 : 4'b0011;
            lane_data  = {2{dmem_wdata_i[15:0]}};
         end
         default: misaligned = (dmem_addr_i[1:0] != 2'b00);
      endcase
   end

   always_comb begin
      load_byte = wb_data_i[{lane_q, 3'b000} +: 8];
      load_half = lane_q[1] ? wb_data_i[31:16] : wb_data_i[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{~usgn_q & load_byte[7]}}, load_byte};
         2'b01:   load_ext = {{16{~usgn_q & load_half[15]}}, load_half};
         default: load_ext = wb_data_i;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (dmem_req_i) state_d = misaligned ? RESP : BUS;
         BUS:  if (wb_ack_i || wb_err_i || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs are computed here one cycle ahead; ack wins over err over timeout.
   always_comb begin
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      gnt_d   = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      size_d  = size_q;
      usgn_d  = usgn_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (dmem_req_i) begin
               size_d = dmem_size_i;
               usgn_d = dmem_usgn_i;
               lane_d = dmem_addr_i[1:0];
               if (misaligned) begin
                  gnt_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  cyc_d  = 1'b1;
                  we_d   = dmem_wren_i;
                  sel_d  = lane_sel;
                  addr_d = {dmem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  wdat_d = lane_data;
                  cnt_d  = '0;
               end
            end
         end
         BUS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (wb_ack_i) begin
               cyc_d   = 1'b0;
               gnt_d   = 1'b1;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'h0 : load_ext;
            end else if (wb_err_i || timeout_hit) begin
               cyc_d   = 1'b0;
               gnt_d   = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         gnt_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         size_q  <= '0;
         usgn_q  <= 1'b0;
         lane_q  <= '0;
         cnt_q   <= '0;
      end else begin
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         usgn_q  <= usgn_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dmem_gnt_o   = gnt_q;
   assign dmem_err_o   = err_q;
   assign dmem_rdata_o = rdata_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign wb_we_o      = we_q;
   assign wb_sel_o     = sel_q;
   assign wb_addr_o    = addr_q;
   assign wb_data_o    = wdat_q;

endmodule
